// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master among NREQ requesters.
// Optional WAIT timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              Clk_i,
  input  logic              Rst_ni,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_sel_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic [7:0]        rdata_o,
  output logic              err_o,
  output logic              m_strobe_o,
  output logic [7:0]        m_toXmit_o,
  output logic [1:0]        m_ss_o,
  input  logic [7:0]        m_Rcvd_i,
  input  logic              m_Ready_i,
  output logic [2:0]        dbg_state_o
);
  // Handshake: a requester holds req_i high until done_o pulses for it; gnt_o
  // stays high from GRANT through DONE; done_o is a single-cycle pulse and
  // rdata_o/err_o are valid in that cycle.
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_STROBE, S_WAIT, S_DONE, S_GAP} state_t;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [NREQ-1:0] gnt_d, done_d;
  logic [7:0]      rdata_d, tx_d, win_data;
  logic [1:0]      ss_d;
  logic            strobe_d, ready_q, ready_d, win_found, win_sel;
  logic [IW-1:0]   win_idx;
  logic [GW-1:0]   gap_q, gap_d;
  int              cand;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err_o = 1'b0;
`endif

  assign dbg_state_o = state_q;

  // Search starts at rr_q, the index after the previous winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req_i[IW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    win_data = '0;
    win_sel  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == IW'(k)) begin
        win_data = req_data_i[8*k +: 8];
        win_sel  = req_sel_i[k];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_o;
    done_d   = '0;
    rdata_d  = rdata_o;
    strobe_d = 1'b0;
    tx_d     = m_toXmit_o;
    ss_d     = m_ss_o;
    gap_d    = gap_q;
    ready_d  = m_Ready_i;
`ifdef SPI_ARB_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = err_o;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          gnt_d   = NREQ'(1) << win_idx;
          tx_d    = win_data;
          ss_d    = win_sel ? 2'b10 : 2'b01;
          rr_d    = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_GRANT: begin
        state_d  = S_STROBE;
        strobe_d = 1'b1;
      end
      S_STROBE: begin
        state_d = S_WAIT;
        // Treat Ready as already high on WAIT entry so only a fresh rising edge completes.
        ready_d = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (m_Ready_i && !ready_q) begin
          state_d = S_DONE;
          done_d  = gnt_o;
          rdata_d = m_Rcvd_i;
          ss_d    = 2'b00;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          done_d  = gnt_o;
          rdata_d = 8'h00;
          ss_d    = 2'b00;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        gnt_d   = '0;
        gap_d   = '0;
        state_d = (GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) state_d = S_IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (!Rst_ni) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      gnt_o      <= '0;
      done_o     <= '0;
      rdata_o    <= '0;
      m_strobe_o <= 1'b0;
      m_toXmit_o <= '0;
      m_ss_o     <= '0;
      gap_q      <= '0;
      ready_q    <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q      <= '0;
      err_o      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gnt_o      <= gnt_d;
      done_o     <= done_d;
      rdata_o    <= rdata_d;
      m_strobe_o <= strobe_d;
      m_toXmit_o <= tx_d;
      m_ss_o     <= ss_d;
      gap_q      <= gap_d;
      ready_q    <= ready_d;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_o      <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: directed scenarios plus randomized
// transfers scored against a round-robin model and an emulated SPI master.
module tb_spi_master_arbiter;
  localparam int NREQ    = 2;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 15;

  logic              Clk_i = 1'b0;
  logic              Rst_ni;
  logic [NREQ-1:0]   req_i;
  logic [8*NREQ-1:0] req_data_i;
  logic [NREQ-1:0]   req_sel_i;
  logic [NREQ-1:0]   gnt_o, done_o;
  logic [7:0]        rdata_o, m_toXmit_o, m_Rcvd_i;
  logic              err_o, m_strobe_o, m_Ready_i;
  logic [1:0]        m_ss_o;
  logic [2:0]        dbg_state_unused;

  spi_master_arbiter #(.NREQ(NREQ), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .Clk_i(Clk_i), .Rst_ni(Rst_ni), .req_i(req_i), .req_data_i(req_data_i),
    .req_sel_i(req_sel_i), .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o),
    .err_o(err_o), .m_strobe_o(m_strobe_o), .m_toXmit_o(m_toXmit_o), .m_ss_o(m_ss_o),
    .m_Rcvd_i(m_Rcvd_i), .m_Ready_i(m_Ready_i), .dbg_state_o(dbg_state_unused)
  );

  // clock / reset
  always #5 Clk_i = ~Clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int tests = 0, fails = 0;
  int cyc = 0, strobes = 0, onehot_bad = 0, stab_bad = 0;
  int last = NREQ - 1, prev_done = -1, rem = 0;
  bit auto_mode = 1'b1, busy = 1'b0, fix_resp = 1'b0;
  logic [7:0] fix_val = '0;
  logic [NREQ-1:0] prev_gnt = '0;
  logic [7:0] prev_tx = '0;
  logic [1:0] prev_ss = '0;

  // scoreboard queues: observed events and model-side stimulus
  int         g_who[$], g_cyc[$], d_who[$], d_cyc[$], lat_q[$];
  logic [7:0] g_tx[$], d_rdata[$], rcvd_q[$];
  logic [1:0] g_ss[$];
  logic [0:0] d_err[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Round-robin reference: first requester after the previous winner.
  function automatic int rr_next(input int prev, input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) if (mask[(prev + k) % NREQ]) return (prev + k) % NREQ;
    return -1;
  endfunction

  // One clock: observe outputs after the edge, then run the SPI master model.
  task automatic tick();
    logic [7:0] resp;
    @(posedge Clk_i); #1;
    cyc++;
    if (!$onehot0(gnt_o)) onehot_bad++;
    if (gnt_o != 0 && prev_gnt == 0) begin
      g_who.push_back(idx_of(gnt_o)); g_cyc.push_back(cyc);
      g_tx.push_back(m_toXmit_o); g_ss.push_back(m_ss_o);
    end
    if (gnt_o != 0 && prev_gnt != 0 && done_o == 0 &&
        (m_toXmit_o != prev_tx || m_ss_o != prev_ss)) stab_bad++;
    if (done_o != 0) begin
      if (!$onehot(done_o)) onehot_bad++;
      d_who.push_back(idx_of(done_o)); d_cyc.push_back(cyc);
      d_rdata.push_back(rdata_o); d_err.push_back(err_o);
    end
    prev_gnt = gnt_o; prev_tx = m_toXmit_o; prev_ss = m_ss_o;
    if (m_strobe_o) strobes++;
    if (auto_mode) begin
      if (m_strobe_o) begin
        m_Ready_i = 1'b0;
        rem = $urandom_range(2, 6);
        lat_q.push_back(rem);
        busy = 1'b1;
      end else if (busy) begin
        rem--;
        if (rem == 0) begin
          resp = fix_resp ? fix_val : 8'($urandom);
          rcvd_q.push_back(resp);
          m_Rcvd_i = resp;
          m_Ready_i = 1'b1;
          busy = 1'b0;
        end
      end
    end
  endtask

  task automatic model_reset();
    last = NREQ - 1; prev_done = -1; busy = 1'b0;
  endtask

  task automatic do_reset(input int n);
    Rst_ni = 1'b0;
    repeat (n) tick();
    Rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < NREQ; k++) begin
      req_data_i[8*k +: 8] = 8'($urandom);
      req_sel_i[k] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt_o, 0);       chk({tag, "_done"}, done_o, 0);
    chk({tag, "_strobe"}, m_strobe_o, 0); chk({tag, "_ss"}, m_ss_o, 0);
    chk({tag, "_tx"}, m_toXmit_o, 0);   chk({tag, "_rdata"}, rdata_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  // Full transfer with the automatic master; req_i is released after done.
  task automatic do_xfer(input logic [NREQ-1:0] mask, input bit drop, input bit scramble);
    int w, n0, dn0, b;
    logic [7:0] exp_tx;
    logic [1:0] exp_ss;
    w = rr_next(last, mask); last = w;
    exp_tx = req_data_i[8*w +: 8];
    exp_ss = req_sel_i[w] ? 2'b10 : 2'b01;
    n0 = g_who.size(); dn0 = d_who.size();
    req_i = mask;
    b = 0;
    while (g_who.size() == n0 && b < 50) begin tick(); b++; end
    if (g_who.size() == n0) begin chk("grant_bound", 0, 1); req_i = '0; return; end
    chk("grant_who", g_who[n0], w);
    chk("grant_tx", g_tx[n0], exp_tx);
    chk("grant_ss", g_ss[n0], exp_ss);
    if (prev_done >= 0) chk("gap_idle", (g_cyc[n0] - prev_done - 1) >= GAP, 1);
    if (scramble) rand_inputs();
    if (drop) begin tick(); tick(); req_i[w] = 1'b0; end
    b = 0;
    while (d_who.size() == dn0 && b < 200) begin tick(); b++; end
    if (d_who.size() == dn0) begin chk("done_bound", 0, 1); req_i = '0; return; end
    chk("done_who", d_who[dn0], w);
    chk("done_rdata", d_rdata[dn0], rcvd_q[$]);
    chk("done_err", d_err[dn0], 0);
    chk("latency", d_cyc[dn0] - g_cyc[n0], lat_q[$] + 2);
    prev_done = d_cyc[dn0];
    req_i = '0;
  endtask

  initial begin
    int n0, dn0, s0, w, b;
    logic [7:0] resp;
    Rst_ni = 1'b0; req_i = '0; req_data_i = '0; req_sel_i = '0;
    m_Rcvd_i = '0; m_Ready_i = 1'b1;
    do_reset(2);
    check_all_zero("reset");

    // single request to slave 1
    fix_resp = 1'b1; fix_val = 8'h3C;
    req_data_i[7:0] = 8'hA5; req_sel_i[0] = 1'b1;
    s0 = strobes; dn0 = d_who.size(); n0 = g_who.size();
    do_xfer(2'b01, 1'b0, 1'b0);
    repeat (8) tick();
    fix_resp = 1'b0;
    chk("single_strobes", strobes - s0, 1);
    chk("single_done_once", d_who.size() - dn0, 1);
    if (g_who.size() > n0) chk("single_ss", g_ss[n0], 2'b10);
    if (g_who.size() > n0) chk("single_tx", g_tx[n0], 8'hA5);
    if (d_who.size() > dn0) chk("single_rdata", d_rdata[dn0], 8'h3C);
    chk("single_gnt_released", gnt_o, 0);

    // simultaneous requests rotate 0,1,0,1 from reset
    do_reset(1);
    rand_inputs();
    n0 = g_who.size();
    for (int i = 0; i < 4; i++) do_xfer(2'b11, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      if (g_who.size() > n0 + i) chk("rotate_order", g_who[n0 + i], i % 2);

    // stale Ready held high through WAIT entry
    auto_mode = 1'b0; m_Ready_i = 1'b1;
    resp = 8'($urandom); m_Rcvd_i = resp;
    w = rr_next(last, 2'b01); last = w;
    s0 = strobes; dn0 = d_who.size();
    req_i = 2'b01;
    b = 0;
    while (strobes == s0 && b < 50) begin tick(); b++; end
    chk("stale_strobe_seen", strobes - s0, 1);
    req_i = '0;
    repeat (6) tick();
    chk("stale_no_done", d_who.size() - dn0, 0);
    m_Ready_i = 1'b0; tick();
    m_Ready_i = 1'b1; tick(); tick(); tick();
    chk("stale_done", d_who.size() - dn0, 1);
    if (d_who.size() > dn0) begin
      chk("stale_rdata", d_rdata[dn0], resp);
      chk("stale_who", d_who[dn0], w);
      prev_done = d_cyc[dn0];
    end
    auto_mode = 1'b1;

    // requester 1 drops req_i during WAIT
    rand_inputs();
    do_xfer(2'b10, 1'b1, 1'b0);

    // randomized transfers
    repeat (10) begin
      rand_inputs();
      do_xfer(NREQ'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // master never completes
    auto_mode = 1'b0; m_Ready_i = 1'b0; m_Rcvd_i = 8'hFF;
    rand_inputs();
    w = rr_next(last, 2'b01); last = w;
    n0 = g_who.size(); dn0 = d_who.size();
    req_i = 2'b01;
    b = 0;
    while (g_who.size() == n0 && b < 50) begin tick(); b++; end
    chk("hang_granted", g_who.size() - n0, 1);
    req_i = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    b = 0;
    while (d_who.size() == dn0 && b < 100) begin tick(); b++; end
    chk("timeout_done", d_who.size() - dn0, 1);
    if (d_who.size() > dn0 && g_who.size() > n0) begin
      chk("timeout_err", d_err[dn0], 1);
      chk("timeout_rdata", d_rdata[dn0], 8'h00);
      chk("timeout_latency", d_cyc[dn0] - g_cyc[n0], TIMEOUT + 2);
      chk("timeout_who", d_who[dn0], w);
    end
    repeat (GAP + 2) tick();
    // start another transfer and leave it waiting
    s0 = strobes;
    req_i = 2'b01;
    b = 0;
    while (strobes == s0 && b < 50) begin tick(); b++; end
    req_i = '0;
    tick(); tick();
`else
    repeat (100) tick();
    chk("hang_no_done", d_who.size() - dn0, 0);
    chk("hang_gnt_held", gnt_o, NREQ'(1) << w);
`endif

    // reset while waiting
    dn0 = d_who.size();
    Rst_ni = 1'b0; tick(); Rst_ni = 1'b1;
    model_reset();
    check_all_zero("wait_reset");
    m_Ready_i = 1'b1; tick();
    repeat (10) tick();
    chk("wait_reset_no_done", d_who.size() - dn0, 0);

    // pointer restarts at requester 0
    auto_mode = 1'b1;
    rand_inputs();
    do_xfer(2'b11, 1'b0, 1'b0);

    chk("gnt_done_onehot", onehot_bad, 0);
    chk("tx_ss_stable", stab_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
